// File: rtl/fp16_unpack.sv
// FP16 input decoder: splits a half-precision word into sign, 7-bit signed exponent
// and an 11-bit mantissa with explicit leading one; subnormals normalize one bit per cycle.
module fp16_unpack (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        sign,
    output logic [6:0]  exp_init,
    output logic [10:0] norm_mant,
    output logic        is_zero,
    output logic        is_inf,
    output logic        is_nan
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        sign_q, sign_d;
    logic [6:0]  exp_q, exp_d;
    logic [10:0] mant_q, mant_d;
    logic        zero_q, zero_d;
    logic        inf_q, inf_d;
    logic        nan_q, nan_d;

    logic        accept;
    logic [4:0]  e_field;
    logic [9:0]  f_field;

    assign e_field = in_data[14:10];
    assign f_field = in_data[9:0];

    // NOTE: every signal written here gets its hold value first, so no path
    // through the case/if tree can leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        sign_d  = sign_q;
        exp_d   = exp_q;
        mant_d  = mant_q;
        zero_d  = zero_q;
        inf_d   = inf_q;
        nan_d   = nan_q;

        in_ready = rst && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
        accept   = in_valid && in_ready;

        case (state_q)
            NORM: begin
                // The bit about to move into position 10 is the leading one.
                mant_d = mant_q << 1;
                exp_d  = exp_q - 7'd1;
                if (mant_q[9]) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: ;
        endcase

        if (accept) begin
            sign_d = in_data[15];
            zero_d = 1'b0;
            inf_d  = 1'b0;
            nan_d  = 1'b0;
            if (e_field == 5'd31) begin
                exp_d   = 7'd31;
                mant_d  = {1'b1, f_field};
                inf_d   = (f_field == 10'd0);
                nan_d   = (f_field != 10'd0);
                state_d = DONE;
            end else if (e_field != 5'd0) begin
                exp_d   = {2'b00, e_field};
                mant_d  = {1'b1, f_field};
                state_d = DONE;
            end else if (f_field == 10'd0) begin
                exp_d   = 7'd0;
                mant_d  = 11'd0;
                zero_d  = 1'b1;
                state_d = DONE;
            end else begin
                exp_d   = 7'd0;
                mant_d  = {1'b0, f_field};
                state_d = NORM;
            end
        end
    end

    // NOTE: state uses non-blocking assignments so every flop samples the
    // pre-edge values, independent of process evaluation order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            sign_q  <= 1'b0;
            exp_q   <= 7'd0;
            mant_q  <= 11'd0;
            zero_q  <= 1'b0;
            inf_q   <= 1'b0;
            nan_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sign_q  <= sign_d;
            exp_q   <= exp_d;
            mant_q  <= mant_d;
            zero_q  <= zero_d;
            inf_q   <= inf_d;
            nan_q   <= nan_d;
        end
    end

    assign out_valid = (state_q == DONE);
    assign sign      = sign_q;
    assign exp_init  = exp_q;
    assign norm_mant = mant_q;
    assign is_zero   = zero_q;
    assign is_inf    = inf_q;
    assign is_nan    = nan_q;

endmodule

// File: tb/tb_fp16_unpack.sv
// Self-checking bench for fp16_unpack: arithmetic reference model plus per-cycle
// compare process, directed corner cases and randomized words with random backpressure.
module tb_fp16_unpack;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic        sign;
    logic [6:0]  exp_init;
    logic [10:0] norm_mant;
    logic        is_zero;
    logic        is_inf;
    logic        is_nan;

    fp16_unpack dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sign      (sign),
        .exp_init  (exp_init),
        .norm_mant (norm_mant),
        .is_zero   (is_zero),
        .is_inf    (is_inf),
        .is_nan    (is_nan)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    typedef struct {
        logic        s;
        logic [6:0]  e;
        logic [10:0] m;
        logic        z;
        logic        inf;
        logic        nan;
        int          lat;
    } model_t;

    typedef struct {
        logic [15:0] w;
        model_t      md;
        int          rdy;
    } item_t;

    // Reference decode written from the numeric meaning of FP16 fields.
    function automatic model_t decode(input logic [15:0] w);
        model_t r;
        int e;
        int f;
        int p;
        e = int'(w[14:10]);
        f = int'(w[9:0]);
        r.s = w[15];
        r.z = 1'b0;
        r.inf = 1'b0;
        r.nan = 1'b0;
        r.lat = 1;
        if (e == 31) begin
            r.e = 7'd31;
            r.m = 11'(1024 + f);
            r.inf = (f == 0);
            r.nan = (f != 0);
        end else if (e > 0) begin
            r.e = 7'(e);
            r.m = 11'(1024 + f);
        end else if (f == 0) begin
            r.e = 7'd0;
            r.m = 11'd0;
            r.z = 1'b1;
        end else begin
            p = 0;
            for (int i = 0; i < 10; i++) if (((f >> i) & 1) == 1) p = i;
            r.m = 11'(f * (1 << (10 - p)));
            r.e = 7'(p - 10);
            r.lat = 1 + (10 - p);
        end
        return r;
    endfunction

    // Inverse of the decode, as the downstream packing stage would do it.
    function automatic logic [15:0] pack(input logic s, input logic [6:0] e, input logic [10:0] m);
        int se;
        se = int'($signed(e));
        if (se > 0) return {s, e[4:0], m[9:0]};
        return {s, 5'd0, 10'(int'(m) >> (-se))};
    endfunction

    // Compare process: checks outputs and in_ready every cycle against the model queue.
    item_t q[$];
    bit    seen_front = 1'b0;

    initial forever begin
        bit    exp_v;
        bit    exp_rdy;
        item_t it;
        @(negedge clk);
        if (!rst) begin
            check("rst_out_valid", out_valid, 0);
            check("rst_in_ready", in_ready, 0);
            check("rst_fields", {sign, exp_init, norm_mant, is_zero, is_inf, is_nan}, 0);
            q.delete();
            seen_front = 1'b0;
        end else begin
            exp_v   = (q.size() > 0) && (cyc >= q[0].rdy);
            exp_rdy = (q.size() == 0) || (exp_v && out_ready);
            check("out_valid", out_valid, exp_v);
            check("in_ready", in_ready, exp_rdy);
            if (exp_v && out_valid) begin
                check("sign", sign, q[0].md.s);
                check("exp_init", exp_init, q[0].md.e);
                check("norm_mant", norm_mant, q[0].md.m);
                check("flags", {is_zero, is_inf, is_nan}, {q[0].md.z, q[0].md.inf, q[0].md.nan});
                if (!seen_front && !q[0].md.z && !q[0].md.inf && !q[0].md.nan)
                    check("round_trip", pack(sign, exp_init, norm_mant), q[0].w);
                seen_front = 1'b1;
            end
            if (exp_v && out_ready) begin
                void'(q.pop_front());
                seen_front = 1'b0;
            end
            if (in_valid && exp_rdy) begin
                it.w   = in_data;
                it.md  = decode(in_data);
                it.rdy = cyc + it.md.lat;
                q.push_back(it);
            end
        end
    end

    // Present w until accepted; returns 1 ns after the accepting edge.
    task automatic send(input logic [15:0] w, input bit rnd_ready);
        in_valid = 1'b1;
        in_data  = w;
        for (int n = 0; ; n++) begin
            if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (in_ready) break;
            if (n > 200) begin
                check("accept_timeout", 0, 1);
                break;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 16'($urandom);
    endtask

    function automatic logic [15:0] rand_word();
        logic [9:0] f;
        case ($urandom_range(0, 9))
            0, 1, 2: begin
                f = 10'($urandom) >> $urandom_range(0, 9);
                if (f == 10'd0) f = 10'd1;
                return {1'($urandom), 5'd0, f};
            end
            3: begin
                case ($urandom_range(0, 2))
                    0: return {1'($urandom), 15'd0};
                    1: return {1'($urandom), 5'd31, 10'd0};
                    default: return {1'($urandom), 5'd31, 10'($urandom_range(1, 1023))};
                endcase
            end
            default: return {1'($urandom), 5'($urandom_range(1, 30)), 10'($urandom)};
        endcase
    endfunction

    model_t md;

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_data   = 16'd0;
        out_ready = 1'b0;

        // Model pins from hand-computed values.
        md = decode(16'h3C00);
        check("pin_3c00", {md.s, md.e, md.m, md.z, md.inf, md.nan}, {1'b0, 7'h0F, 11'h400, 3'b000});
        check("pin_3c00_lat", md.lat, 1);
        md = decode(16'h0001);
        check("pin_0001", {md.e, md.m}, {7'h76, 11'h400});
        check("pin_0001_lat", md.lat, 11);
        md = decode(16'h8200);
        check("pin_8200", {md.s, md.e, md.m}, {1'b1, 7'h7F, 11'h400});
        check("pin_8200_lat", md.lat, 2);
        md = decode(16'h7C00);
        check("pin_7c00", {md.e, md.m, md.inf, md.nan}, {7'd31, 11'h400, 2'b10});
        md = decode(16'h7E00);
        check("pin_7e00", {md.e, md.m, md.inf, md.nan}, {7'd31, 11'h600, 2'b01});
        md = decode(16'h0000);
        check("pin_0000", {md.e, md.m, md.z, md.lat[3:0]}, {7'd0, 11'd0, 1'b1, 4'd1});

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;

        // Normal word, 1-cycle latency.
        out_ready = 1'b1;
        send(16'h3C00, 1'b0);
        @(negedge clk);
        check("d_3c00", {out_valid, sign, exp_init, norm_mant, is_zero, is_inf, is_nan},
              {1'b1, 1'b0, 7'h0F, 11'h400, 3'b000});
        @(posedge clk);
        #1;

        // Subnormal extremes and specials, checked by the compare process.
        send(16'h0001, 1'b0);
        repeat (12) @(posedge clk);
        #1;
        send(16'h8200, 1'b0);
        send(16'h7C00, 1'b0);
        send(16'h7E00, 1'b0);
        send(16'h0000, 1'b0);
        repeat (3) @(posedge clk);
        #1;

        // Backpressure, then back-to-back accept with no bubble.
        out_ready = 1'b0;
        send(16'h4500, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_hold", {out_valid, in_ready, exp_init, norm_mant}, {1'b1, 1'b0, 7'h11, 11'h500});
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        send(16'h3800, 1'b0);
        @(negedge clk);
        check("bp_next", {out_valid, exp_init, norm_mant}, {1'b1, 7'h0E, 11'h400});
        @(posedge clk);
        #1;
        repeat (2) @(posedge clk);
        #1;

        // Reset in the middle of normalization.
        send(16'h0001, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("rst_mid_norm", {out_valid, in_ready, sign, exp_init, norm_mant, is_zero, is_inf, is_nan}, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("rst_release_ready", in_ready, 1);
        @(posedge clk);
        #1;
        send(16'h3C00, 1'b0);
        @(negedge clk);
        check("post_rst_3c00", {out_valid, exp_init, norm_mant}, {1'b1, 7'h0F, 11'h400});
        @(posedge clk);
        #1;

        // Random words with random backpressure and gaps.
        for (int k = 0; k < 400; k++) begin
            send(rand_word(), 1'b1);
            repeat ($urandom_range(0, 2)) begin
                out_ready = ($urandom_range(0, 3) != 0);
                @(posedge clk);
                #1;
            end
        end

        out_ready = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (!out_valid) break;
        end
        check("drain", out_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
